irq_ctrl: RTL and testbench

- Interrupt controller that sits directly downstream of the timer/counter peripherals and other request sources.
- Latches the sources' interrupt requests, masks them, and arbitrates them by fixed priority.
- Presents one request plus a vector to the CPU core, and returns a one-cycle interrupt_executed pulse to the serviced source.
- Exposes enable, mask and pending registers on the shared 8-bit peripheral register bus.

---
 rtl/irq_ctrl_if.sv | 29 ++
 rtl/irq_ctrl.sv | 164 ++++++++++++++++
 tb/tb_irq_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_if.sv
// Signal bundle between irq_ctrl and its environment: request sources, the CPU
// interrupt handshake and the shared 8-bit peripheral register bus.
interface irq_ctrl_if #(
  parameter int N_SRC = 4
);
  logic [N_SRC-1:0] irq_req;
  logic [N_SRC-1:0] irq_done;
  logic             cpu_irq;
  logic [7:0]       cpu_vec;
  logic             cpu_ack;
  logic             cpu_reti;
  logic [7:0]       addr;
  logic [7:0]       wdata;
  logic             write;
  logic             read;
  logic [7:0]       rdata;

  // The controller side.
  modport slave (
    input  irq_req, cpu_ack, cpu_reti, addr, wdata, write, read,
    output irq_done, cpu_irq, cpu_vec, rdata
  );

  // Sources, CPU and bus master seen as one driver.
  modport master (
    output irq_req, cpu_ack, cpu_reti, addr, wdata, write, read,
    input  irq_done, cpu_irq, cpu_vec, rdata
  );
endinterface

// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller: edge-latched pending bits, per-source mask,
// global enable I, and a single-level IDLE/REQ/SERVICE/DONE handshake with the CPU.
module irq_ctrl #(
  parameter int         N_SRC      = 4,
  parameter logic [7:0] VEC_BASE   = 8'h02,
  parameter logic [7:0] VEC_STRIDE = 8'h02,
  parameter logic [7:0] ADDR_SREG  = 8'h5f,
  parameter logic [7:0] ADDR_MSK   = 8'h6f,
  parameter logic [7:0] ADDR_PND   = 8'h3f
) (
  input  logic        clk,
  input  logic        rst,
  irq_ctrl_if.slave   bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]       state_q,   state_d;
  logic [2:0]       idx_q,     idx_d;
  logic             i_q,       i_d;
  logic [N_SRC-1:0] mask_q,    mask_d;
  logic [N_SRC-1:0] pend_q,    pend_d;
  logic [N_SRC-1:0] req_q;
  logic [N_SRC-1:0] done_q,    done_d;
  logic             cpu_irq_q, cpu_irq_d;
  logic [7:0]       cpu_vec_q, cpu_vec_d;
  logic [7:0]       rdata_q,   rdata_d;

  logic             wr_sreg, wr_msk, wr_pnd, rd_en;
  logic             hw_i_clr, hw_i_set;
  logic [N_SRC-1:0] rise, elig, sw_clr, hw_clr, idx_onehot;
  logic [2:0]       win;
  logic [7:0]       win_vec;

  assign wr_sreg = bus.write && (bus.addr == ADDR_SREG);
  assign wr_msk  = bus.write && (bus.addr == ADDR_MSK);
  assign wr_pnd  = bus.write && (bus.addr == ADDR_PND);
  assign rd_en   = bus.read && !bus.write;

  // Only a 0->1 transition latches a request, so a held level cannot re-pend.
  assign rise       = bus.irq_req & ~req_q;
  assign elig       = pend_q & mask_q & {N_SRC{i_q}};
  assign idx_onehot = N_SRC'(1) << idx_q;

  // Walk from the top so the lowest eligible index is the one that sticks.
  always_comb begin
    win = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (elig[i]) win = 3'(i);
    end
  end

  assign win_vec = VEC_BASE + 8'(win) * VEC_STRIDE;

  // NOTE: every signal written here gets a default first, otherwise the
  // unassigned paths would infer latches.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cpu_irq_d = cpu_irq_q;
    cpu_vec_d = cpu_vec_q;
    done_d    = '0;
    hw_clr    = '0;
    hw_i_clr  = 1'b0;
    hw_i_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|elig) begin
          idx_d     = win;
          cpu_vec_d = win_vec;
          cpu_irq_d = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        // Selection is frozen here; a simultaneous reti is dropped in favour of ack.
        if (bus.cpu_ack) begin
          cpu_irq_d = 1'b0;
          hw_i_clr  = 1'b1;
          state_d   = SERVICE;
        end
      end
      SERVICE: begin
        if (bus.cpu_reti) begin
          done_d  = idx_onehot;
          state_d = DONE;
        end
      end
      DONE: begin
        hw_clr   = idx_onehot;
        hw_i_set = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    i_d     = i_q;
    mask_d  = mask_q;
    sw_clr  = '0;
    rdata_d = rdata_q;

    if (wr_sreg) i_d    = bus.wdata[7];
    if (wr_msk)  mask_d = bus.wdata[N_SRC-1:0];
    if (wr_pnd)  sw_clr = bus.wdata[N_SRC-1:0];

    // Hardware updates of I override a software write in the same cycle.
    if (hw_i_clr) i_d = 1'b0;
    if (hw_i_set) i_d = 1'b1;

    pend_d = (pend_q & ~(sw_clr | hw_clr)) | rise;

    if (rd_en) begin
      case (bus.addr)
        ADDR_SREG: rdata_d = {i_q, 7'b0};
        ADDR_MSK:  rdata_d = 8'(mask_q);
        ADDR_PND:  rdata_d = 8'(pend_q);
        default:   rdata_d = 8'h00;
      endcase
    end
  end

  // NOTE: every flop sits in the async reset so a reset mid-service drops the
  // interrupt outright and can never leave a stale irq_done behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      i_q       <= 1'b0;
      mask_q    <= '0;
      pend_q    <= '0;
      req_q     <= '0;
      done_q    <= '0;
      cpu_irq_q <= 1'b0;
      cpu_vec_q <= '0;
      rdata_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      idx_q     <= idx_d;
      i_q       <= i_d;
      mask_q    <= mask_d;
      pend_q    <= pend_d;
      req_q     <= bus.irq_req;
      done_q    <= done_d;
      cpu_irq_q <= cpu_irq_d;
      cpu_vec_q <= cpu_vec_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.irq_done = done_q;
  assign bus.cpu_irq  = cpu_irq_q;
  assign bus.cpu_vec  = cpu_vec_q;
  assign bus.rdata    = rdata_q;

  a_done_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(done_q));
  a_irq_in_req:  assert property (@(posedge clk) disable iff (rst) cpu_irq_q == (state_q == REQ));

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: register access table plus hand-written service sequences,
// with read data and CPU vectors checked through expectation queues.
module tb_irq_ctrl;

  localparam int         N    = 4;
  localparam logic [7:0] SREG = 8'h5f;
  localparam logic [7:0] MSK  = 8'h6f;
  localparam logic [7:0] PND  = 8'h3f;

  typedef struct {
    logic [7:0] wa;
    logic [7:0] wd;
    logic [7:0] ra;
    logic [7:0] exp;
    string      name;
  } reg_vec_t;

  logic clk = 1'b0;
  logic rst;

  irq_ctrl_if #(.N_SRC(N)) bus ();

  irq_ctrl #(.N_SRC(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] rd_q[$];
  logic [7:0] vec_q[$];
  reg_vec_t   tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [7:0] exp, input string name);
    bus.addr = a;
    bus.read = 1'b1;
    rd_q.push_back(exp);
    tick();
    bus.read = 1'b0;
    if (rd_q.size() == 0) check({name, "_queue"}, 1, 0);
    else                  check(name, bus.rdata, rd_q.pop_front());
  endtask

  task automatic pulse_req(input logic [N-1:0] m);
    bus.irq_req = m;
    tick();
    bus.irq_req = '0;
  endtask

  task automatic wait_irq(input string name);
    int         n = 0;
    logic [7:0] exp;
    while (bus.cpu_irq !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    exp = (vec_q.size() != 0) ? vec_q.pop_front() : 8'hxx;
    if (bus.cpu_irq !== 1'b1) check({name, "_timeout"}, bus.cpu_irq, 1);
    else                      check(name, bus.cpu_vec, exp);
  endtask

  task automatic service(input logic [N-1:0] exp_done, input string name);
    bus.cpu_ack = 1'b1;
    tick();
    bus.cpu_ack = 1'b0;
    check({name, "_irq_after_ack"}, bus.cpu_irq, 0);
    bus.cpu_reti = 1'b1;
    tick();
    bus.cpu_reti = 1'b0;
    check({name, "_done"}, bus.irq_done, exp_done);
    tick();
    check({name, "_done_one_cycle"}, bus.irq_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{SREG,  8'h80, SREG,  8'h80, "sreg_set"};
    tbl[1] = '{SREG,  8'h7f, SREG,  8'h00, "sreg_i_only"};
    tbl[2] = '{MSK,   8'hff, MSK,   8'h0f, "msk_upper_zero"};
    tbl[3] = '{MSK,   8'h05, MSK,   8'h05, "msk_pattern"};
    tbl[4] = '{8'h10, 8'hff, 8'h10, 8'h00, "unmapped"};
    tbl[5] = '{PND,   8'hff, PND,   8'h00, "pnd_w1c_empty"};
    tbl[6] = '{MSK,   8'h00, MSK,   8'h00, "msk_clear"};
    tbl[7] = '{8'h5e, 8'hff, SREG,  8'h00, "near_sreg_addr"};

    rst          = 1'b1;
    bus.irq_req  = '0;
    bus.cpu_ack  = 1'b0;
    bus.cpu_reti = 1'b0;
    bus.addr     = '0;
    bus.wdata    = '0;
    bus.write    = 1'b0;
    bus.read     = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_cpu_irq",  bus.cpu_irq,  0);
    check("rst_cpu_vec",  bus.cpu_vec,  0);
    check("rst_irq_done", bus.irq_done, 0);
    check("rst_rdata",    bus.rdata,    0);
    bus_read(SREG, 8'h00, "rst_sreg");
    bus_read(MSK,  8'h00, "rst_msk");
    bus_read(PND,  8'h00, "rst_pnd");

    for (int k = 0; k < 8; k++) begin
      bus_write(tbl[k].wa, tbl[k].wd);
      bus_read(tbl[k].ra, tbl[k].exp, tbl[k].name);
    end

    // Write wins over read; rdata holds when no read is issued.
    bus_write(SREG, 8'h80);
    bus_read(SREG, 8'h80, "sreg_before_wr_rd");
    bus.addr  = MSK;
    bus.wdata = 8'h03;
    bus.write = 1'b1;
    bus.read  = 1'b1;
    tick();
    bus.write = 1'b0;
    bus.read  = 1'b0;
    check("wr_over_rd_hold", bus.rdata, 8'h80);
    bus_read(MSK, 8'h03, "wr_over_rd_msk");
    tick();
    check("rdata_hold", bus.rdata, 8'h03);
    bus_write(MSK, 8'h00);

    // Basic service of source 2.
    bus_write(MSK, 8'h0f);
    vec_q.push_back(8'h06);
    pulse_req(4'b0100);
    wait_irq("basic_vec");
    bus.cpu_ack = 1'b1;
    tick();
    bus.cpu_ack = 1'b0;
    check("basic_irq_after_ack", bus.cpu_irq, 0);
    bus_read(SREG, 8'h00, "basic_sreg_cleared");
    bus.cpu_reti = 1'b1;
    tick();
    bus.cpu_reti = 1'b0;
    check("basic_done", bus.irq_done, 4'b0100);
    tick();
    check("basic_done_one_cycle", bus.irq_done, 0);
    bus_read(PND,  8'h00, "basic_pnd_cleared");
    bus_read(SREG, 8'h80, "basic_sreg_restored");

    // Priority: sources 1 and 3 together.
    vec_q.push_back(8'h04);
    vec_q.push_back(8'h08);
    pulse_req(4'b1010);
    wait_irq("prio_first_vec");
    service(4'b0010, "prio_first");
    wait_irq("prio_second_vec");
    service(4'b1000, "prio_second");

    // Masked source 0 held high: pends, never fires, cleared by software.
    bus_write(MSK, 8'h0e);
    bus.irq_req = 4'b0001;
    tick();
    tick();
    bus_read(PND, 8'h01, "mask_pnd_set");
    check("mask_no_irq", bus.cpu_irq, 0);
    bus_write(PND, 8'h01);
    bus_read(PND, 8'h00, "mask_pnd_w1c_held");
    bus.irq_req = '0;
    bus_write(MSK, 8'h0f);
    repeat (3) tick();
    check("mask_unmask_no_irq", bus.cpu_irq, 0);

    // Global enable gating.
    bus_write(SREG, 8'h00);
    pulse_req(4'b0010);
    repeat (3) tick();
    check("gate_no_irq", bus.cpu_irq, 0);
    vec_q.push_back(8'h04);
    bus_write(SREG, 8'h80);
    tick();
    check("gate_irq_next_cycle", bus.cpu_irq, 1);
    check("gate_vec", bus.cpu_vec, vec_q.size() != 0 ? vec_q.pop_front() : 8'hxx);
    service(4'b0010, "gate");

    // Frozen selection in REQ, no nesting during SERVICE.
    vec_q.push_back(8'h06);
    pulse_req(4'b0100);
    wait_irq("frozen_vec");
    pulse_req(4'b0001);
    bus_write(SREG, 8'h00);
    tick();
    check("frozen_irq_held", bus.cpu_irq, 1);
    check("frozen_vec_held", bus.cpu_vec, 8'h06);
    bus.cpu_ack = 1'b1;
    tick();
    bus.cpu_ack = 1'b0;
    bus_write(SREG, 8'h80);
    repeat (3) tick();
    check("no_nest_irq", bus.cpu_irq, 0);
    bus_read(PND, 8'h05, "no_nest_pnd");
    bus.cpu_reti = 1'b1;
    tick();
    bus.cpu_reti = 1'b0;
    check("frozen_done", bus.irq_done, 4'b0100);
    vec_q.push_back(8'h02);
    wait_irq("after_frozen_vec");
    service(4'b0001, "after_frozen");

    // ack and reti together in REQ: only the ack counts.
    vec_q.push_back(8'h08);
    pulse_req(4'b1000);
    wait_irq("ackreti_vec");
    bus.cpu_ack  = 1'b1;
    bus.cpu_reti = 1'b1;
    tick();
    bus.cpu_ack  = 1'b0;
    bus.cpu_reti = 1'b0;
    check("ackreti_irq", bus.cpu_irq, 0);
    check("ackreti_no_done", bus.irq_done, 0);
    tick();
    check("ackreti_no_done_late", bus.irq_done, 0);
    bus.cpu_reti = 1'b1;
    tick();
    bus.cpu_reti = 1'b0;
    check("ackreti_done", bus.irq_done, 4'b1000);
    tick();

    // Reset while in SERVICE.
    vec_q.push_back(8'h04);
    pulse_req(4'b0010);
    wait_irq("rstsvc_vec");
    bus.cpu_ack = 1'b1;
    tick();
    bus.cpu_ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rstsvc_cpu_irq",  bus.cpu_irq,  0);
    check("rstsvc_irq_done", bus.irq_done, 0);
    tick();
    rst = 1'b0;
    bus_read(PND,  8'h00, "rstsvc_pnd");
    bus_read(MSK,  8'h00, "rstsvc_msk");
    bus_read(SREG, 8'h00, "rstsvc_sreg");
    bus.cpu_reti = 1'b1;
    tick();
    bus.cpu_reti = 1'b0;
    check("rstsvc_stray_reti", bus.irq_done, 0);
    tick();
    check("rstsvc_stray_reti_late", bus.irq_done, 0);
    check("rstsvc_no_irq", bus.cpu_irq, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
